uart_tx_arbiter: RTL
====================

# uart_tx_arbiter

Round-robin arbiter that shares one `uart_tx` serializer among `N_REQ` byte-producing requesters. It grants one requester per frame and latches its byte. It then pulses `uart_tx`'s enable and holds the grant until the serializer reports `done`. A watchdog recovers the arbiter if `done` never arrives. It sits between the bus-side producers and the `uart_tx` instance, sharing its clock and reset.

## Interface
- `N_REQ`, 4, number of requesters (2..8); `ID_W = $clog2(N_REQ)`
- `TIMEOUT_CYCLES`, 5208, max cycles in WAIT before abort (12 bit-times at 434 clocks/bit)
- `clock`  in  1  system clock, rising edge
- `reset`  in  1  asynchronous, active-low reset
- `req`  in  N_REQ  request per requester, level
- `req_data`  in  8*N_REQ  byte of requester i on bits [8i+7:8i], stable while `req[i]`=1
- `ack`  out  N_REQ  one-hot, one-cycle pulse: byte of requester i accepted
- `grant_id`  out  ID_W  index of last/current granted requester
- `busy`  out  1  high when state != IDLE
- `timeout_err`  out  1  one-cycle pulse on watchdog abort
- `tx_readdata`  out  8  byte to `uart_tx.readdata`
- `tx_enable`  out  1  one-cycle start pulse to `uart_tx.enable`
- `tx_active`  in  1  `uart_tx.active`; status only, used for debug/assertions
- `tx_done`  in  1  `uart_tx.done`; one-cycle pulse at end of stop bit

## Operation
- States: IDLE, START, WAIT. Reset enters IDLE.
- IDLE: if `req` != 0, select the winner by round-robin.
  - Search order is `last+1, last+2, …` mod N_REQ, where `last` is the previous winner.
  - Reset value of `last` is N_REQ-1, so req[0] has first priority.
  - On the edge: latch `req_data[winner]` into `tx_readdata`, set `grant_id`=winner, update `last`, and go to START.
- START (exactly 1 cycle): `tx_enable`=1, `ack[grant_id]`=1. Clear the watchdog counter. Go to WAIT.
- WAIT: counter increments each cycle.
  - `tx_done`=1: go to IDLE.
  - Else, if counter = TIMEOUT_CYCLES-1: pulse `timeout_err` and go to IDLE. No retry; the byte is lost, and it was already acked.
- Requester rule: after `ack`, the requester deasserts `req` or presents its next byte before the frame ends. `req` still high at the next IDLE is a new byte.
- `tx_done` in IDLE or START is ignored (stale).
- `tx_active` does not affect state transitions.
- Non-requesting slots are skipped in the search. `last` moves only on a grant.
- Reset values: `ack`=0, `grant_id`=0, `busy`=0, `timeout_err`=0, `tx_readdata`=0, `tx_enable`=0, counter=0, `last`=N_REQ-1.
- Reset asserted mid-frame: everything returns to reset values immediately (asynchronous). `uart_tx` shares `reset`, so it aborts too. There are no pending grants after release.

## Timing
- All outputs are registered.
- Request seen in IDLE at edge k → `tx_enable`, `ack`, `busy`=1 during cycle k+1.
- `uart_tx` samples enable at edge k+2, then serializes 10 bits.
- `tx_done` high in cycle d → IDLE in cycle d+1 (`busy`=0). The next `tx_enable` is at cycle d+2 if a request is pending.
- Back-to-back gap: 2 cycles between `done` and the next enable.
- Worst-case wait for requester i (all requesting): (N_REQ-1) frames plus 2 cycles each.
- Watchdog: abort `timeout_err` asserted in cycle START+TIMEOUT_CYCLES. `busy` is low the cycle after.

## Test plan
- Single request: `req`=0001, data 8'h0F.
  - Expected: one `ack[0]` pulse, one `tx_enable` pulse, `tx_readdata`=8'h0F.
  - Real `uart_tx` (434 clocks/bit) emits 0,11110000,1 LSB-first; `busy` drops 1 cycle after `done`.
- All four request simultaneously with data 8'hA0..8'hA3, each dropping `req` after its ack.
  - Expected: grants 0,1,2,3 in order; tx line carries A0,A1,A2,A3; exactly 4 acks.
- Fairness: `req[0]` and `req[2]` held high for 6 frames.
  - Expected: grant sequence 0,2,0,2,0,2; never two consecutive grants to one requester.
- Watchdog: replace `uart_tx` with a model that never pulses `done`; `req`=0010.
  - Expected: `timeout_err` pulse exactly TIMEOUT_CYCLES cycles after START.
  - Then IDLE and a regrant of requester 1 two cycles later.
- Stale done: pulse `tx_done` while IDLE with `req`=0.
  - Expected: no state change, no ack, no enable.
- Reset mid-frame: assert `reset`=0 halfway through the second of two queued frames.
  - Expected: all outputs 0 immediately.
  - After release with `req`=0001, requester 0 is granted first (`last` reset).

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_tx serializer among N_REQ byte producers.
// One grant per frame. A watchdog abandons a frame whose done pulse never arrives.
module uart_tx_arbiter #(
    parameter int unsigned N_REQ          = 4,
    parameter int unsigned TIMEOUT_CYCLES = 5208,
    localparam int unsigned ID_W          = $clog2(N_REQ)
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [N_REQ-1:0]     req,
    input  logic [8*N_REQ-1:0]   req_data,
    output logic [N_REQ-1:0]     ack,
    output logic [ID_W-1:0]      grant_id,
    output logic                 busy,
    output logic                 timeout_err,
    output logic [7:0]           tx_readdata,
    output logic                 tx_enable,
    input  logic                 tx_active,
    input  logic                 tx_done
);

    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    typedef enum logic [1:0] {
        IDLE,
        START,
        WAIT
    } state_t;

    state_t             state;
    logic [ID_W-1:0]    last;
    logic [ID_W-1:0]    winner;
    logic [7:0]         winner_data;
    logic [CNT_W-1:0]   count;
    logic               tx_stuck;

    // Search last+1, last+2, ... wrapping at N_REQ; first requesting slot wins.
    always_comb begin
        logic        found;
        int unsigned idx;
        found  = 1'b0;
        idx    = 0;
        winner = '0;
        for (int unsigned off = 1; off <= N_REQ; off++) begin
            idx = 32'(last) + off;
            if (idx >= N_REQ) begin
                idx = idx - N_REQ;
            end
            if (!found && req[ID_W'(idx)]) begin
                found  = 1'b1;
                winner = ID_W'(idx);
            end
        end
    end

    always_comb begin
        winner_data = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (winner == ID_W'(i)) begin
                winner_data = req_data[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            last        <= ID_W'(N_REQ - 1);
            grant_id    <= '0;
            ack         <= '0;
            busy        <= 1'b0;
            timeout_err <= 1'b0;
            tx_readdata <= '0;
            tx_enable   <= 1'b0;
            count       <= '0;
            tx_stuck    <= 1'b0;
        end else begin
            ack         <= '0;
            tx_enable   <= 1'b0;
            timeout_err <= 1'b0;
            if (tx_done) begin
                tx_stuck <= 1'b0;
            end
            case (state)
                IDLE: begin
                    if (|req) begin
                        tx_readdata <= winner_data;
                        grant_id    <= winner;
                        last        <= winner;
                        ack         <= N_REQ'(1) << winner;
                        tx_enable   <= 1'b1;
                        busy        <= 1'b1;
                        state       <= START;
                    end
                end
                START: begin
                    count <= '0;
                    state <= WAIT;
                end
                WAIT: begin
                    if (tx_done) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else if (count == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        busy     <= 1'b0;
                        tx_stuck <= 1'b1;
                        state    <= IDLE;
                    end else begin
                        count <= count + 1'b1;
                        // Registered one cycle early so the pulse coincides with the
                        // final WAIT cycle and busy falls on the cycle after it.
                        timeout_err <= (count == CNT_W'(TIMEOUT_CYCLES - 2));
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    a_ack_onehot: assert property (@(posedge clock) disable iff (!reset) $onehot0(ack));

    // The serializer must be idle when started, unless a previous frame was abandoned.
    a_start_idle: assert property (@(posedge clock) disable iff (!reset)
        (tx_enable && !tx_stuck) |-> !tx_active);

endmodule
